control_client: RTL and testbench
=================================

Name: control_client

Overview:
- AXI-lite master that lets a processing node or scheduler reach the control block's register space without hand-coding AXI handshakes.
- Accepts one read or write command at a time on a valid/ready command port.
- Drives exactly one AXI-lite transaction per command.
- Returns read data, an error flag and the measured transaction latency on a valid/ready response port.

Parameters:
- ADDR_W, `AXI_ADDR_WIDTH, AXI and command address width.
- DATA_W, `AXI_DATA_WIDTH, AXI and command data width.
- LAT_W, 16, width of the saturating latency counter.

Ports:
- clk  in  1  clock.
- res_n  in  1  reset; one clock, reset asynchronous active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  resp field was not OKAY.
- rsp_cycles  out  LAT_W  cycles from first AXI valid to resp handshake, saturating.
- m_axi  if  if_axi_light.master  AXI-lite master port, using standard aw/w/b/ar/r channel signals.

Behaviour:
- Reset (async, res_n=0): state IDLE; all m_axi valid/ready outputs 0; cmd_ready=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; rsp_cycles=0; latches 0.
- Reset mid-transaction: the transaction is abandoned and all valids drop immediately. No response is produced.
- All outputs are registered.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_addr/cmd_wdata, clear the latency counter, go to WR_REQ (cmd_write=1) or RD_REQ. cmd_ready falls the same edge.
  - cmd_valid is ignored in every other state.
- WR_REQ:
  - Drive awvalid=1, awaddr=latched, awprot=0 and wvalid=1, wdata=latched, wstrb=all ones.
  - AW and W are independent. Each valid stays high through its handshake cycle and drops the next cycle. Address/data stay stable while valid.
  - Once both handshakes have completed (same or different cycles), next state WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: rsp_err=bresp[1], rsp_rdata=0, bready drops, go to RSP.
- RD_REQ: arvalid=1, araddr=latched, arprot=0. After the arready handshake, go to RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: rsp_rdata=rdata, rsp_err=rresp[1], go to RSP.
- RSP:
  - rsp_valid=1; rsp_rdata, rsp_err and rsp_cycles held stable.
  - On rsp_ready: rsp_valid=0, go to IDLE. The next command can be accepted the cycle after.
- Latency counter:
  - Increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - Saturates at 2^LAT_W-1 with no wrap.
  - The value captured into rsp_cycles includes the b/r handshake cycle.
- Best case, write with responder always ready and bvalid held:
  - edge 0 accept;
  - cycle 1 aw/w valid;
  - cycle 2 bready with bvalid;
  - cycle 3 rsp_valid;
  - rsp_cycles=2.
  - Reads have the same timing.
- No timeout: the block waits indefinitely for the responder.
- Response errors (SLVERR/DECERR) only set rsp_err; the FSM proceeds normally.
- bvalid/rvalid arriving while bready/rready is low is not sampled.

Test Plan:
- Write addr 0x0000_008C (prog bit 7, node 3), data 0x0000_1000, responder always ready, bvalid on the first bready cycle -> aw/w valid 1 cycle, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0, rsp_cycles=2.
- Read addr 0x0000_0100 (busy), responder returns rdata=0x0000_0009 after arready delayed 4 cycles -> arvalid held 5 cycles with stable araddr, rsp_rdata=0x9, rsp_err=0, rsp_cycles=6.
- Write with wready at cycle 1 but awready at cycle 5 -> wvalid drops after cycle 1, awvalid held to cycle 5, bready only asserted from cycle 6.
- Responder returns bresp=2'b10 -> rsp_err=1. The next read returning OKAY -> rsp_err=0.
- rsp_ready held low 10 cycles, cmd_valid high throughout -> rsp fields stable, cmd_ready=0, no new AXI activity. On rsp_ready the queued command is accepted the cycle after IDLE is re-entered.
- res_n pulsed low while awvalid=1 -> awvalid/wvalid 0 asynchronously, no rsp_valid. After release, cmd_ready=1 and a fresh read completes correctly.

Source files
------------

// File: rtl/control_client.sv
// rtl/control_client.sv - AXI-lite master executing one register read/write per command
// Returns read data, error flag and saturating transaction latency on a response port.
module control_client #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT_W  = 16
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [LAT_W-1:0]  rsp_cycles,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [LAT_W-1:0]  lat_inc;
  logic              aw_done;
  logic              w_done;
  logic              unused_resp_lsb;

  assign lat_inc = (lat_cnt == {LAT_W{1'b1}}) ? lat_cnt : lat_cnt + LAT_W'(1);

  // A channel is done once its valid has dropped or is handshaking this cycle.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = {(DATA_W/8){1'b1}};

  assign unused_resp_lsb = &{1'b0, m_axi_bresp[0], m_axi_rresp[0]};

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_cycles    <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      lat_cnt       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            lat_cnt   <= '0;
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              state         <= WR_REQ;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= RD_REQ;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          lat_cnt <= lat_inc;
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state        <= WR_RESP;
            m_axi_bready <= 1'b1;
          end
        end
        WR_RESP: begin
          lat_cnt <= lat_inc;
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= m_axi_bresp[1];
            rsp_cycles   <= lat_inc;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_REQ: begin
          lat_cnt <= lat_inc;
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          lat_cnt <= lat_inc;
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_err      <= m_axi_rresp[1];
            rsp_cycles   <= lat_inc;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_client.sv
// tb/tb_control_client.sv - self-checking bench for control_client
// Scripted AXI-lite responder with per-transaction delays; latency expected from channel delays.
module tb_control_client;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT_W  = 5;
  localparam int MAXLAT = (1 << LAT_W) - 1;

  logic              clk = 1'b0;
  logic              res_n;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [LAT_W-1:0]  rsp_cycles;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]        m_axi_awprot, m_axi_arprot;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rready;
  logic [1:0]        m_axi_bresp, m_axi_rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_client #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .res_n(res_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_cycles(rsp_cycles),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  task automatic clear_responder();
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
  endtask

  // d1: AW/AR stall cycles, d2: W stall cycles, d3: B/R stall cycles after ready rises.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input int d1, input int d2, input int d3, input logic [1:0] resp,
                        input logic [31:0] rdata, input int hold, input logic queue_next);
    int req_len, bs, total;
    logic exp_v, exp_w, exp_rdy, exp_err;
    logic [31:0] exp_rdata;
    logic [LAT_W-1:0] exp_cyc;
    req_len   = (wr && d2 > d1) ? d2 : d1;
    bs        = req_len + 2;
    total     = req_len + 1 + d3 + 1;
    exp_cyc   = LAT_W'((total > MAXLAT) ? MAXLAT : total);
    exp_err   = resp[1];
    exp_rdata = wr ? 32'h0 : rdata;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_before_accept: got %b expected 1", cmd_ready); end
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom;
    for (int c = 1; c <= bs + d3; c++) begin
      exp_v   = (c <= d1 + 1);
      exp_w   = wr && (c <= d2 + 1);
      exp_rdy = (c >= bs);
      if (wr) begin
        checks++;
        if (m_axi_awvalid !== exp_v || m_axi_wvalid !== exp_w || m_axi_arvalid !== 1'b0) begin
          errors++; $display("FAIL wr_valids c=%0d: got aw=%b w=%b ar=%b expected aw=%b w=%b ar=0",
                             c, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, exp_v, exp_w);
        end
        checks++;
        if (m_axi_bready !== exp_rdy) begin errors++; $display("FAIL bready c=%0d: got %b expected %b", c, m_axi_bready, exp_rdy); end
        if (exp_v) begin
          checks++;
          if (m_axi_awaddr !== addr || m_axi_awprot !== 3'b0) begin
            errors++; $display("FAIL awaddr c=%0d: got %h/%0d expected %h/0", c, m_axi_awaddr, m_axi_awprot, addr);
          end
        end
        if (exp_w) begin
          checks++;
          if (m_axi_wdata !== data || m_axi_wstrb !== 4'hF) begin
            errors++; $display("FAIL wdata c=%0d: got %h/%h expected %h/f", c, m_axi_wdata, m_axi_wstrb, data);
          end
        end
        m_axi_awready = (c == d1 + 1);
        m_axi_wready  = (c == d2 + 1);
        if (c < bs) begin
          m_axi_bvalid = 1'($urandom_range(0, 1)); m_axi_bresp = ~resp;
        end else begin
          m_axi_bvalid = (c == bs + d3); m_axi_bresp = m_axi_bvalid ? resp : ~resp;
        end
      end else begin
        checks++;
        if (m_axi_arvalid !== exp_v || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
          errors++; $display("FAIL rd_valids c=%0d: got ar=%b aw=%b w=%b expected ar=%b aw=0 w=0",
                             c, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, exp_v);
        end
        checks++;
        if (m_axi_rready !== exp_rdy) begin errors++; $display("FAIL rready c=%0d: got %b expected %b", c, m_axi_rready, exp_rdy); end
        if (exp_v) begin
          checks++;
          if (m_axi_araddr !== addr || m_axi_arprot !== 3'b0) begin
            errors++; $display("FAIL araddr c=%0d: got %h/%0d expected %h/0", c, m_axi_araddr, m_axi_arprot, addr);
          end
        end
        m_axi_arready = (c == d1 + 1);
        if (c < bs) begin
          m_axi_rvalid = 1'($urandom_range(0, 1)); m_axi_rresp = ~resp; m_axi_rdata = ~rdata;
        end else begin
          m_axi_rvalid = (c == bs + d3);
          m_axi_rresp  = m_axi_rvalid ? resp : ~resp;
          m_axi_rdata  = m_axi_rvalid ? rdata : ~rdata;
        end
      end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_early c=%0d: got %b expected 0", c, rsp_valid); end
      @(negedge clk);
    end
    clear_responder();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err || rsp_cycles !== exp_cyc) begin
      errors++; $display("FAIL rsp: got v=%b d=%h e=%b cyc=%0d expected v=1 d=%h e=%b cyc=%0d",
                         rsp_valid, rsp_rdata, rsp_err, rsp_cycles, exp_rdata, exp_err, exp_cyc);
    end
    checks++;
    if (m_axi_bready !== 1'b0 || m_axi_rready !== 1'b0) begin
      errors++; $display("FAIL resp_ready_drop: got b=%b r=%b expected 0", m_axi_bready, m_axi_rready);
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 0; cmd_valid = queue_next; cmd_write = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err || rsp_cycles !== exp_cyc) begin
        errors++; $display("FAIL rsp_hold h=%0d: got v=%b d=%h e=%b cyc=%0d expected v=1 d=%h e=%b cyc=%0d",
                           h, rsp_valid, rsp_rdata, rsp_err, rsp_cycles, exp_rdata, exp_err, exp_cyc);
      end
      checks++;
      if (cmd_ready !== 1'b0 || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_arvalid !== 1'b0) begin
        errors++; $display("FAIL hold_quiet h=%0d: got rdy=%b aw=%b w=%b ar=%b expected 0",
                           h, cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid);
      end
    end
    cmd_valid = queue_next;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL after_rsp: got v=%b rdy=%b aw=%b ar=%b expected v=0 rdy=1 aw=0 ar=0",
                         rsp_valid, cmd_ready, m_axi_awvalid, m_axi_arvalid);
    end
  endtask

  task automatic test_reset();
    res_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    clear_responder();
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 8'b0
        || rsp_rdata !== 32'h0 || rsp_cycles !== 5'h0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%b v=%b e=%b d=%h cyc=%0d axi=%b expected all 0",
                         cmd_ready, rsp_valid, rsp_err, rsp_rdata, rsp_cycles,
                         {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    res_n = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_after_reset: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_best_write();
    do_txn(1, 32'h0000_008C, 32'h0000_1000, 0, 0, 0, 2'b00, 32'h0, 0, 0);
  endtask

  task automatic test_read_delay();
    do_txn(0, 32'h0000_0100, 32'h0, 4, 0, 0, 2'b00, 32'h0000_0009, 0, 0);
  endtask

  task automatic test_split_write();
    do_txn(1, 32'h0000_0040, 32'hDEAD_BEEF, 4, 0, 0, 2'b00, 32'h0, 0, 0);
    do_txn(1, 32'h0000_0044, 32'h1234_5678, 0, 3, 2, 2'b00, 32'h0, 0, 0);
  endtask

  task automatic test_errors();
    do_txn(1, 32'h0000_0010, 32'h0000_0001, 0, 0, 1, 2'b10, 32'h0, 0, 0);
    do_txn(0, 32'h0000_0014, 32'h0, 0, 0, 0, 2'b00, 32'h0000_00A5, 0, 0);
    do_txn(0, 32'h0000_0018, 32'h0, 1, 0, 2, 2'b11, 32'hFFFF_0000, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_txn(1, 32'h0000_0020, 32'h0000_0077, 1, 0, 0, 2'b00, 32'h0, 10, 1);
    do_txn(0, 32'h0000_0024, 32'h0, 0, 0, 0, 2'b00, 32'h0000_0ABC, 0, 0);
  endtask

  task automatic test_saturation();
    do_txn(0, 32'h0000_0030, 32'h0, MAXLAT - 2, 0, 0, 2'b00, 32'h1, 0, 0);
    do_txn(0, 32'h0000_0034, 32'h0, MAXLAT - 1, 0, 0, 2'b00, 32'h2, 0, 0);
    do_txn(1, 32'h0000_0038, 32'h3, 20, 25, 15, 2'b00, 32'h0, 0, 0);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0050; cmd_wdata = 32'h55;
    @(negedge clk);
    cmd_valid = 0;
    checks++;
    if (m_axi_awvalid !== 1'b1) begin errors++; $display("FAIL awvalid_before_reset: got %b expected 1", m_axi_awvalid); end
    #1 res_n = 0;
    #1;
    checks++;
    if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL async_reset: got aw=%b w=%b v=%b rdy=%b expected 0",
                         m_axi_awvalid, m_axi_wvalid, rsp_valid, cmd_ready);
    end
    repeat (2) @(negedge clk);
    res_n = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || m_axi_bready !== 1'b0) begin
        errors++; $display("FAIL no_rsp_after_reset: got v=%b bready=%b expected 0", rsp_valid, m_axi_bready);
      end
    end
    do_txn(0, 32'h0000_0060, 32'h0, 1, 0, 1, 2'b00, 32'hCAFE_F00D, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4),
             2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_best_write();
    test_read_delay();
    test_split_write();
    test_errors();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
